// File: rtl/adder_delay_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : adder_delay_counter
// Description : Ring-oscillator edge counter for adder delay measurement.
//               Counts synchronized rising edges of ring_in over a programmable
//               window of wb_clk_i cycles; saturating count with overflow flag.
//               Optional macro ADDER_DELAY_COUNTER_GLITCH_FILTER_EN enables a
//               2-high-after-2-low edge qualifier (ARM grows to 3 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module adder_delay_counter #(
    parameter int CNT_W = 32,
    parameter int WIN_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             ring_in,
    input  logic             start,
    input  logic [WIN_W-1:0] window_cycles,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ARM length is C_ARM_LAST + 1 cycles; long enough to flush the edge pipe
`ifdef ADDER_DELAY_COUNTER_GLITCH_FILTER_EN
    localparam logic [1:0] C_ARM_LAST = 2'd2;
`else
    localparam logic [1:0] C_ARM_LAST = 2'd1;
`endif
    localparam logic [WIN_W-1:0] C_WIN_ONE = WIN_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rise;
    state_t           r_state;
    logic [1:0]       r_arm_cnt;
    logic [WIN_W-1:0] r_window;
    logic [WIN_W-1:0] r_remain;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;
    logic             r_overflow;
    logic             r_busy;
    logic             r_done;

    // Two-flop synchronizer for the asynchronous ring oscillator output
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ring_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef ADDER_DELAY_COUNTER_GLITCH_FILTER_EN
    logic [2:0] r_hist;

    // History of the synchronized level: [0] is one cycle old, [2] three
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_hist <= 3'b000;
        end else begin
            r_hist <= {r_hist[1:0], r_sync2};
        end
    end

    // Qualified edge: high for two cycles after being low for at least two
    assign w_rise = r_sync2 & r_hist[0] & ~r_hist[1] & ~r_hist[2];
`else
    logic r_hist;

    // Single history flop for plain rising-edge detection
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_hist <= 1'b0;
        end else begin
            r_hist <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_hist;
`endif

    assign w_count_inc = r_count + C_CNT_ONE;

    // Measurement FSM: accept start, flush the edge pipe, count, then hold
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_state    <= S_IDLE;
            r_arm_cnt  <= 2'd0;
            r_window   <= '0;
            r_remain   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_window   <= window_cycles;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_arm_cnt  <= 2'd0;
                        r_state    <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (r_arm_cnt == C_ARM_LAST) begin
                        if (r_window == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state  <= S_COUNT;
                            r_remain <= r_window;
                        end
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 2'd1;
                    end
                end
                S_COUNT: begin
                    // Saturate at all-ones; overflow flags reaching the ceiling
                    if (w_rise && !(&r_count)) begin
                        r_count <= w_count_inc;
                        if (&w_count_inc) begin
                            r_overflow <= 1'b1;
                        end
                    end
                    r_remain <= r_remain - C_WIN_ONE;
                    if (r_remain == C_WIN_ONE) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_adder_delay_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_adder_delay_counter
// Description : Scoreboard bench for adder_delay_counter (default build and
//               ADDER_DELAY_COUNTER_GLITCH_FILTER_EN build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_delay_counter;

`ifdef ADDER_DELAY_COUNTER_GLITCH_FILTER_EN
    localparam int C_ARM = 3;
`else
    localparam int C_ARM = 2;
`endif

    typedef struct {
        int lo;
        int hi;
        bit ovf;
        int lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ring_a = 1'b0;
    logic        start_a = 1'b0;
    logic [15:0] win_a = '0;
    logic        busy_a;
    logic        done_a;
    logic [31:0] count_a;
    logic        ovf_a;
    logic        ring_b = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] win_b = '0;
    logic        busy_b;
    logic        done_b;
    logic [3:0]  count_b;
    logic        ovf_b;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   per_a = 0;
    int   ph_a = 0;
    int   per_b = 0;
    int   ph_b = 0;

    always #5 clk = ~clk;

    adder_delay_counter #(.CNT_W(32), .WIN_W(16)) u_dut_a (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .ring_in(ring_a), .start(start_a),
        .window_cycles(win_a), .busy(busy_a), .done(done_a), .count(count_a),
        .overflow(ovf_a)
    );

    adder_delay_counter #(.CNT_W(4), .WIN_W(16)) u_dut_b (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .ring_in(ring_b), .start(start_b),
        .window_cycles(win_b), .busy(busy_b), .done(done_b), .count(count_b),
        .overflow(ovf_b)
    );

    // Square-wave ring sources, period in clocks (0 = held low)
    always @(negedge clk) begin
        if (per_a == 0) begin
            ring_a = 1'b0; ph_a = 0;
        end else begin
            ring_a = (ph_a < per_a / 2); ph_a = (ph_a + 1) % per_a;
        end
        if (per_b == 0) begin
            ring_b = 1'b0; ph_b = 0;
        end else begin
            ring_b = (ph_b < per_b / 2); ph_b = (ph_b + 1) % per_b;
        end
    end

    // Pulse start for one cycle and record the expected result
    task automatic launch(input bit sel, input logic [15:0] win, input exp_t e);
        @(negedge clk);
        if (sel) begin start_b = 1'b1; win_b = win; end
        else     begin start_a = 1'b1; win_a = win; end
        sb.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Observe until done; latency counted in cycles since the start cycle
    task automatic collect(input bit sel, input int lat_in, output int lat,
                           output logic [31:0] cnt, output logic ovf,
                           output bit busy_ok, output bit tmo);
        lat = lat_in; busy_ok = 1'b1; tmo = 1'b0;
        while (1) begin
            if (sel ? done_b : done_a) break;
            if ((sel ? busy_b : busy_a) !== 1'b1) busy_ok = 1'b0;
            if (lat >= 1000) begin tmo = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        cnt = sel ? {28'd0, count_b} : count_a;
        ovf = sel ? ovf_b : ovf_a;
    endtask

    task automatic test_reset();
        exp_t e; int lat; logic [31:0] cnt; logic ovf; bit bok; bit tmo;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
        n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_a); end
        n_tests++; if (count_a !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_a); end
        n_tests++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf_a); end
        e = '{lo: 0, hi: 0, ovf: 1'b0, lat: C_ARM + 1};
        launch(1'b0, 16'd0, e);
        n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL start_busy got %b want 1", busy_a); end
        collect(1'b0, 1, lat, cnt, ovf, bok, tmo);
        e = sb.pop_front();
        n_tests++; if (tmo || lat != e.lat) begin n_fail++; $display("FAIL reset_run_latency got %0d want %0d", lat, e.lat); end
    endtask

    task automatic test_window_100();
        exp_t e; int lat; logic [31:0] cnt; logic ovf; bit bok; bit tmo; bit stable;
        per_a = 8;
        e = '{lo: 12, hi: 13, ovf: 1'b0, lat: C_ARM + 101};
        launch(1'b0, 16'd100, e);
        collect(1'b0, 1, lat, cnt, ovf, bok, tmo);
        e = sb.pop_front();
        n_tests++; if (tmo || lat != e.lat) begin n_fail++; $display("FAIL w100_latency got %0d want %0d", lat, e.lat); end
        n_tests++; if ($isunknown(cnt) || cnt < e.lo || cnt > e.hi) begin n_fail++; $display("FAIL w100_count got %0d want %0d..%0d", cnt, e.lo, e.hi); end
        n_tests++; if (ovf !== e.ovf) begin n_fail++; $display("FAIL w100_ovf got %b want %b", ovf, e.ovf); end
        n_tests++; if (!bok || busy_a !== 1'b0) begin n_fail++; $display("FAIL w100_busy got ok=%b at_done=%b want ok=1 at_done=0", bok, busy_a); end
        stable = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (count_a !== cnt || done_a !== 1'b1) stable = 1'b0;
        end
        n_tests++; if (!stable) begin n_fail++; $display("FAIL done_hold got count=%0d done=%b want count=%0d done=1", count_a, done_a, cnt); end
    endtask

    task automatic test_zero_window();
        exp_t e; int lat; logic [31:0] cnt; logic ovf; bit bok; bit tmo;
        per_a = 4;
        e = '{lo: 0, hi: 0, ovf: 1'b0, lat: C_ARM + 1};
        launch(1'b0, 16'd0, e);
        collect(1'b0, 1, lat, cnt, ovf, bok, tmo);
        e = sb.pop_front();
        n_tests++; if (tmo || lat != e.lat) begin n_fail++; $display("FAIL w0_latency got %0d want %0d", lat, e.lat); end
        n_tests++; if (cnt !== 32'(e.lo)) begin n_fail++; $display("FAIL w0_count got %0d want %0d", cnt, e.lo); end
        n_tests++; if (ovf !== e.ovf) begin n_fail++; $display("FAIL w0_ovf got %b want %b", ovf, e.ovf); end
    endtask

    task automatic test_overflow();
        exp_t e; int lat; logic [31:0] cnt; logic ovf; bit bok; bit tmo;
        per_b = 4;
        e = '{lo: 15, hi: 15, ovf: 1'b1, lat: C_ARM + 201};
        launch(1'b1, 16'd200, e);
        collect(1'b1, 1, lat, cnt, ovf, bok, tmo);
        e = sb.pop_front();
        n_tests++; if (tmo || lat != e.lat) begin n_fail++; $display("FAIL ovf_latency got %0d want %0d", lat, e.lat); end
        n_tests++; if (cnt !== 32'(e.lo)) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", cnt, e.lo); end
        n_tests++; if (ovf !== e.ovf) begin n_fail++; $display("FAIL ovf_flag got %b want %b", ovf, e.ovf); end
        per_b = 0;
    endtask

    task automatic test_ignored_start();
        exp_t e; int lat; logic [31:0] cnt; logic ovf; bit bok; bit tmo;
        per_a = 8;
        e = '{lo: 12, hi: 13, ovf: 1'b0, lat: C_ARM + 101};
        launch(1'b0, 16'd100, e);
        repeat (40) @(negedge clk);
        start_a = 1'b1; win_a = 16'd5;
        @(negedge clk);
        start_a = 1'b0;
        collect(1'b0, 42, lat, cnt, ovf, bok, tmo);
        e = sb.pop_front();
        n_tests++; if (tmo || lat != e.lat) begin n_fail++; $display("FAIL ign_latency got %0d want %0d", lat, e.lat); end
        n_tests++; if ($isunknown(cnt) || cnt < e.lo || cnt > e.hi) begin n_fail++; $display("FAIL ign_count got %0d want %0d..%0d", cnt, e.lo, e.hi); end
        n_tests++; if (!bok) begin n_fail++; $display("FAIL ign_busy got dropped want held"); end
    endtask

    task automatic test_restart_from_done();
        exp_t e; int lat; logic [31:0] cnt; logic ovf; bit bok; bit tmo;
        n_tests++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL pre_restart_done got %b want 1", done_a); end
        e = '{lo: 0, hi: 0, ovf: 1'b0, lat: C_ARM + 1};
        launch(1'b0, 16'd0, e);
        n_tests++; if (done_a !== 1'b0 || busy_a !== 1'b1) begin n_fail++; $display("FAIL restart_clear got done=%b busy=%b want done=0 busy=1", done_a, busy_a); end
        n_tests++; if (count_a !== 32'd0) begin n_fail++; $display("FAIL restart_count got %0d want 0", count_a); end
        collect(1'b0, 1, lat, cnt, ovf, bok, tmo);
        e = sb.pop_front();
        n_tests++; if (tmo || lat != e.lat) begin n_fail++; $display("FAIL restart_latency got %0d want %0d", lat, e.lat); end
    endtask

    task automatic test_reset_mid();
        exp_t e; int lat; logic [31:0] cnt; logic ovf; bit bok; bit tmo; bit saw_done;
        per_a = 8;
        @(negedge clk);
        start_a = 1'b1; win_a = 16'd100;
        @(negedge clk);
        start_a = 1'b0;
        repeat (48) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got busy=%b done=%b want 0 0", busy_a, done_a); end
        n_tests++; if (count_a !== 32'd0 || ovf_a !== 1'b0) begin n_fail++; $display("FAIL midrst_count got %0d/%b want 0/0", count_a, ovf_a); end
        saw_done = 1'b0;
        repeat (120) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0) saw_done = 1'b1;
        end
        n_tests++; if (saw_done) begin n_fail++; $display("FAIL midrst_idle got activity want none"); end
        e = '{lo: 0, hi: 0, ovf: 1'b0, lat: C_ARM + 1};
        launch(1'b0, 16'd0, e);
        collect(1'b0, 1, lat, cnt, ovf, bok, tmo);
        e = sb.pop_front();
        n_tests++; if (tmo || lat != e.lat || cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_rerun got lat=%0d cnt=%0d want lat=%0d cnt=0", lat, cnt, e.lat); end
    endtask

    initial begin
        test_reset();
        test_window_100();
        test_zero_window();
        test_overflow();
        test_ignored_start();
        test_restart_from_done();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/adder_delay_counter.md
ADDER_DELAY_COUNTER -- requirements
Module: adder_delay_counter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the edge count result.
REQ-002 The block SHALL have parameter WIN_W, default 16, giving the width of the measurement window length.
REQ-003 The block SHALL have port wb_clk_i, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port wb_rst_n, input, width 1: reset, synchronous and active-low.
REQ-005 The block SHALL have port ring_in, input, width 1: asynchronous ring-oscillator output (instrumented adder chain_out).
REQ-006 The block SHALL have port start, input, width 1: a one-cycle request to begin a measurement.
REQ-007 The block SHALL have port window_cycles, input, width WIN_W: the measurement window length in clocks, sampled on an accepted start.
REQ-008 The block SHALL have port busy, output, width 1: high while a measurement is in progress.
REQ-009 The block SHALL have port done, output, width 1: sticky level, high once a result is valid.
REQ-010 The block SHALL have port count, output, width CNT_W: number of ring_in rising edges counted in the window.
REQ-011 The block SHALL have port overflow, output, width 1: high if count saturated during the window.

Function
REQ-012 ring_in SHALL pass through a 2-flop synchronizer, followed by one history flop used for edge detection.
REQ-013 A rising edge SHALL be the synchronized level equal to 1 while the history flop equals 0.
REQ-014 The FSM SHALL have four states: IDLE, ARM, COUNT, DONE.
REQ-015 In IDLE or DONE, start=1 SHALL be accepted: window_cycles latched, count and overflow cleared, done cleared, and the FSM moves to ARM on the next cycle.
REQ-016 busy SHALL be 1 from the cycle after the accepted start until the cycle the FSM enters DONE.
REQ-017 ARM SHALL last exactly 2 cycles to flush the synchronizer; no edges SHALL be counted in ARM.
REQ-018 COUNT SHALL last exactly the latched window_cycles cycles, and edges SHALL be counted only in those cycles.
REQ-019 In the cycle after the last COUNT cycle, the FSM SHALL enter DONE with done=1, busy=0, and count/overflow frozen.
REQ-020 A latched window_cycles of 0 SHALL skip COUNT and go from ARM to DONE with count=0.
REQ-021 start while in ARM or COUNT SHALL be ignored, with no effect on the window or the count.
REQ-022 start in DONE SHALL restart the measurement as in IDLE.
REQ-023 On reaching all-ones, count SHALL hold there and overflow SHALL be set for the remainder of the measurement.
REQ-024 count SHALL remain readable and stable in DONE until the next accepted start.
REQ-025 The maximum countable edge rate SHALL be wb_clk_i/2; faster input is out of contract.

Reset
REQ-026 wb_rst_n=0 at a rising clock edge SHALL force IDLE with busy=0, done=0, count=0 and overflow=0.
REQ-027 Reset SHALL clear the synchronizer and history flops to 0, and the latched window to 0.
REQ-028 Reset asserted mid-measurement SHALL abort it with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-029 Macro ADDER_DELAY_COUNTER_GLITCH_FILTER_EN SHALL be supported.
REQ-030 With ADDER_DELAY_COUNTER_GLITCH_FILTER_EN defined, an edge SHALL count only when the synchronized level has been 1 for 2 consecutive cycles after being 0 for at least 2 cycles; this costs 1 extra cycle of edge latency, the maximum rate becomes wb_clk_i/4, and ARM lasts 3 cycles.
REQ-031 With ADDER_DELAY_COUNTER_GLITCH_FILTER_EN undefined, edge detection SHALL follow REQ-013 and ARM SHALL last 2 cycles.

Verification
REQ-032 Reset held 3 cycles, then released -> busy=0, done=0, count=0, overflow=0; start in cycle 5 -> busy=1 in cycle 6.
REQ-033 window_cycles=100, ring_in a square wave of period 8 clocks -> done after 103 cycles (2 ARM + 100 COUNT + 1), count=12 or 13.
REQ-034 window_cycles=0 -> done 3 cycles after start, count=0, overflow=0.
REQ-035 CNT_W=4, window_cycles=200, ring_in period 4 clocks -> count=15, overflow=1.
REQ-036 start pulsed mid-COUNT with window_cycles=5 -> ignored, and the original window of 100 completes with an unchanged count; a second start in DONE clears done the next cycle.
REQ-037 wb_rst_n=0 at cycle 50 of a 100-cycle window -> IDLE next cycle, done never set, count=0.
